// File: rtl/sc_ball_shifter.sv
// Player-1 pong ball shifter: one-hot ball in bits 7..4, moved one step per game tick.
// Define SC_BALLSHIFTER_SPEEDUP_EN to shorten the tick period after each successful paddle hit.
module sc_ball_shifter #(
    parameter int                   DATAWIDTH       = 8,
    parameter int                   PRESCALER_WIDTH = 24,
    parameter int                   TICK_DIV        = 12500000,
    parameter logic [DATAWIDTH-1:0] SERVE_VALUE     = 8'b01000000
) (
    input  logic                 SC_BALLSHIFTER_CLOCK_50,
    input  logic                 SC_BALLSHIFTER_RESET_InLow,
    input  logic                 SC_BALLSHIFTER_start_InLow,
    input  logic                 SC_BALLSHIFTER_hit_InLow,
    input  logic                 SC_BALLSHIFTER_izquierda_InLow,
    input  logic                 SC_BALLSHIFTER_derecha_InLow,
    output logic [DATAWIDTH-1:0] SC_BALLSHIFTER_data_OutBUS,
    output logic                 SC_BALLSHIFTER_miss_OutLow,
    output logic                 SC_BALLSHIFTER_tick_OutHigh
);

    typedef enum logic [1:0] {IDLE, MOVE_LEFT, MOVE_RIGHT, MISS} state_t;

    localparam logic [PRESCALER_WIDTH-1:0] TICK_DIV_W = PRESCALER_WIDTH'(TICK_DIV);
    localparam logic [PRESCALER_WIDTH-1:0] ONE_W      = PRESCALER_WIDTH'(1);

    state_t                      state;
    logic [PRESCALER_WIDTH-1:0]  prescaler;
    logic [PRESCALER_WIDTH-1:0]  reload;
    logic [DATAWIDTH-1:0]        data;
    logic                        miss_n;
    logic                        moving;
    logic                        tick;
    logic                        hit_ok;

    assign moving = (state == MOVE_LEFT) || (state == MOVE_RIGHT);
    assign tick   = moving && (prescaler == reload - ONE_W);
    assign hit_ok = tick && (state == MOVE_LEFT) && (data != '0)
                    && !SC_BALLSHIFTER_izquierda_InLow && !SC_BALLSHIFTER_hit_InLow;

`ifdef SC_BALLSHIFTER_SPEEDUP_EN
    localparam logic [PRESCALER_WIDTH-1:0] FLOOR_W = PRESCALER_WIDTH'(TICK_DIV >> 2);

    logic [PRESCALER_WIDTH-1:0] reload_dec;
    logic [PRESCALER_WIDTH-1:0] reload_next;

    always_comb begin
        reload_dec  = reload - (reload >> 3);
        reload_next = (reload_dec < FLOOR_W) ? FLOOR_W : reload_dec;
    end

    // Reload shrinks on each returned ball and is restored on every serve.
    always_ff @(posedge SC_BALLSHIFTER_CLOCK_50 or negedge SC_BALLSHIFTER_RESET_InLow) begin
        if (!SC_BALLSHIFTER_RESET_InLow) begin
            reload <= TICK_DIV_W;
        end else if (state == IDLE && !SC_BALLSHIFTER_start_InLow) begin
            reload <= TICK_DIV_W;
        end else if (hit_ok) begin
            reload <= reload_next;
        end
    end
`else
    assign reload = TICK_DIV_W;
`endif

    always_ff @(posedge SC_BALLSHIFTER_CLOCK_50 or negedge SC_BALLSHIFTER_RESET_InLow) begin
        if (!SC_BALLSHIFTER_RESET_InLow) begin
            state     <= IDLE;
            data      <= '0;
            miss_n    <= 1'b1;
            prescaler <= '0;
        end else begin
            miss_n <= 1'b1;
            case (state)
                IDLE: begin
                    prescaler <= '0;
                    if (!SC_BALLSHIFTER_start_InLow) begin
                        data  <= SERVE_VALUE;
                        state <= MOVE_RIGHT;
                    end
                end
                MOVE_RIGHT, MOVE_LEFT: begin
                    if (!tick) begin
                        prescaler <= prescaler + ONE_W;
                    end else begin
                        prescaler <= '0;
                        // An empty vector can only come from corruption; drop back without a miss.
                        if (data == '0) begin
                            state <= IDLE;
                        end else if (state == MOVE_RIGHT) begin
                            if (!SC_BALLSHIFTER_derecha_InLow) begin
                                state <= MOVE_LEFT;
                                data  <= data << 1;
                            end else begin
                                data <= data >> 1;
                            end
                        end else if (SC_BALLSHIFTER_izquierda_InLow) begin
                            data <= data << 1;
                        end else if (!SC_BALLSHIFTER_hit_InLow) begin
                            state <= MOVE_RIGHT;
                            data  <= data >> 1;
                        end else begin
                            state  <= MISS;
                            data   <= '0;
                            miss_n <= 1'b0;
                        end
                    end
                end
                MISS: begin
                    prescaler <= '0;
                    state     <= IDLE;
                end
                default: begin
                    prescaler <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign SC_BALLSHIFTER_data_OutBUS  = data;
    assign SC_BALLSHIFTER_miss_OutLow  = miss_n;
    assign SC_BALLSHIFTER_tick_OutHigh = tick;

endmodule
